// File: rtl/hazard_stall_controller.sv
// Hazard/stall sequencer for the ID stage of a 5-stage MIPS pipeline.
// Detects load-use hazards, taken-branch flushes and data-memory waits, drives
// the hold/flush/bubble/freeze controls and keeps saturating statistics.
module hazard_stall_controller #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES    = 1,
  parameter int unsigned MEM_TIMEOUT     = 64,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Instruction_IF_ID,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic             Branch_Taken,
  input  logic             Mem_Busy,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             Bubble_Sel,
  output logic             Pipe_Freeze,
  output logic             Mem_Timeout,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    S_RUN,
    S_LU_STALL,
    S_FLUSH,
    S_MEM_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       uses_rt;
  logic       lu_hazard;
  logic       run_eval;
  logic       unused_imm;

  assign op         = Instruction_IF_ID[31:26];
  assign rs         = Instruction_IF_ID[25:21];
  assign rt         = Instruction_IF_ID[20:16];
  assign unused_imm = ^Instruction_IF_ID[15:0];

  // Decode whether the ID instruction reads rt as a source, then detect load-use
  always_comb begin
    uses_rt   = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    lu_hazard = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                ((ID_EX_Rt == rs) || (uses_rt && (ID_EX_Rt == rt)));
  end

  // Next-state and control outputs; a released MEM_WAIT falls through to the RUN decision
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_eval    = 1'b0;
    PC_Write    = 1'b0;
    IF_ID_Write = 1'b0;
    IF_ID_Flush = 1'b0;
    Bubble_Sel  = 1'b0;
    Pipe_Freeze = 1'b0;

    unique case (state_q)
      S_RUN: run_eval = 1'b1;
      S_LU_STALL: begin
        if (Mem_Busy) begin
          PC_Write    = 1'b1;
          IF_ID_Write = 1'b1;
          Pipe_Freeze = 1'b1;
          state_d     = S_MEM_WAIT;
          cnt_d       = CW'(1);
        end else begin
          PC_Write    = 1'b1;
          IF_ID_Write = 1'b1;
          Bubble_Sel  = 1'b1;
          if (cnt_q <= CW'(1)) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_FLUSH: begin
        if (Mem_Busy) begin
          PC_Write    = 1'b1;
          IF_ID_Write = 1'b1;
          Pipe_Freeze = 1'b1;
          state_d     = S_MEM_WAIT;
          cnt_d       = CW'(1);
        end else begin
          IF_ID_Flush = 1'b1;
          if (cnt_q <= CW'(1)) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_MEM_WAIT: begin
        if (Mem_Busy) begin
          PC_Write    = 1'b1;
          IF_ID_Write = 1'b1;
          Pipe_Freeze = 1'b1;
          if (cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          run_eval = 1'b1;
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase

    if (run_eval) begin
      if (Mem_Busy) begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        Pipe_Freeze = 1'b1;
        state_d     = S_MEM_WAIT;
        cnt_d       = CW'(1);
      end else if (lu_hazard) begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        Bubble_Sel  = 1'b1;
        if (LU_STALL_CYCLES > 1) begin
          state_d = S_LU_STALL;
          cnt_d   = CW'(LU_STALL_CYCLES - 1);
        end else begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end else if (Branch_Taken) begin
        IF_ID_Flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = S_FLUSH;
          cnt_d   = CW'(FLUSH_CYCLES - 1);
        end else begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end else begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    end

    // Reset fills the pipe with NOPs and aborts any sequence in progress
    if (rst) begin
      state_d     = S_RUN;
      cnt_d       = '0;
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b1;
      Bubble_Sel  = 1'b1;
      Pipe_Freeze = 1'b0;
    end
  end

  // Sticky timeout and saturating statistics for the current cycle's controls
  always_comb begin
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Pipe_Freeze && (32'(cnt_d) >= MEM_TIMEOUT)) begin
      timeout_d = 1'b1;
    end
    if (PC_Write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (IF_ID_Flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State, sequence counter, timeout flag and statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Mem_Timeout = timeout_q;
  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller. Instance a: LU=1, FLUSH=2, TIMEOUT=4.
// Instance b: LU=3, FLUSH=1, TIMEOUT=64, 4-bit counters for saturation.
module tb_hazard_stall_controller;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        mem_read;
  logic [4:0]  ex_rt;
  logic        br_taken;
  logic        mem_busy;

  logic        a_pcw, a_ifw, a_fl, a_bub, a_frz, a_to;
  logic [31:0] a_stall, a_flush;
  logic        b_pcw, b_ifw, b_fl, b_bub, b_frz, b_to;
  logic [3:0]  b_stall, b_flush;

  int unsigned errors;
  int unsigned checks;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, Bubble_Sel, Pipe_Freeze}
  localparam logic [4:0] C_IDLE  = 5'b00000;
  localparam logic [4:0] C_LU    = 5'b11010;
  localparam logic [4:0] C_FLUSH = 5'b00100;
  localparam logic [4:0] C_FRZ   = 5'b11001;
  localparam logic [4:0] C_RST   = 5'b11110;

  localparam logic [31:0] I_ADD_R2  = {6'h00, 5'd2, 5'd4, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] I_ADD_R0  = {6'h00, 5'd0, 5'd0, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] I_ADDI_R5 = {6'h08, 5'd1, 5'd5, 16'h0004};
  localparam logic [31:0] I_SW_R5   = {6'h2B, 5'd1, 5'd5, 16'h0008};

  hazard_stall_controller #(
    .LU_STALL_CYCLES(1), .FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(32)
  ) dut_a (
    .clk(clk), .rst(rst), .Instruction_IF_ID(instr), .ID_EX_MemRead(mem_read),
    .ID_EX_Rt(ex_rt), .Branch_Taken(br_taken), .Mem_Busy(mem_busy),
    .PC_Write(a_pcw), .IF_ID_Write(a_ifw), .IF_ID_Flush(a_fl), .Bubble_Sel(a_bub),
    .Pipe_Freeze(a_frz), .Mem_Timeout(a_to), .Stall_Count(a_stall), .Flush_Count(a_flush)
  );

  hazard_stall_controller #(
    .LU_STALL_CYCLES(3), .FLUSH_CYCLES(1), .MEM_TIMEOUT(64), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .Instruction_IF_ID(instr), .ID_EX_MemRead(mem_read),
    .ID_EX_Rt(ex_rt), .Branch_Taken(br_taken), .Mem_Busy(mem_busy),
    .PC_Write(b_pcw), .IF_ID_Write(b_ifw), .IF_ID_Flush(b_fl), .Bubble_Sel(b_bub),
    .Pipe_Freeze(b_frz), .Mem_Timeout(b_to), .Stall_Count(b_stall), .Flush_Count(b_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ctrl_a();
    return {a_pcw, a_ifw, a_fl, a_bub, a_frz};
  endfunction

  function automatic logic [4:0] ctrl_b();
    return {b_pcw, b_ifw, b_fl, b_bub, b_frz};
  endfunction

  // Let combinational outputs settle on newly driven inputs
  task automatic settle();
    #2;
  endtask

  // Advance one clock; inputs stay away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic mr, input logic [4:0] rt,
                       input logic br, input logic mb);
    instr    = i;
    mem_read = mr;
    ex_rt    = rt;
    br_taken = br;
    mem_busy = mb;
    settle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    drive(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Reset: NOP-fill controls, counters clear
    check("rst_ctrl_a", 32'(ctrl_a()), 32'(C_RST));
    step();
    step();
    settle();
    check("rst_ctrl_b", 32'(ctrl_b()), 32'(C_RST));
    check("rst_stall_a", a_stall, 32'd0);
    check("rst_flush_a", a_flush, 32'd0);
    check("rst_timeout_a", 32'(a_to), 32'd0);
    rst = 1'b0;
    settle();
    check("run_idle_a", 32'(ctrl_a()), 32'(C_IDLE));

    // 1. lw $2 then add $3,$2,$4: one-cycle stall
    drive(I_ADD_R2, 1'b1, 5'd2, 1'b0, 1'b0);
    check("lu_ctrl", 32'(ctrl_a()), 32'(C_LU));
    step();
    drive(I_ADD_R2, 1'b0, 5'd0, 1'b0, 1'b0);
    check("lu_done", 32'(ctrl_a()), 32'(C_IDLE));
    check("lu_stallcnt", a_stall, 32'd1);

    // 2. Load into $0, addi using rt, and sw using rt
    drive(I_ADD_R0, 1'b1, 5'd0, 1'b0, 1'b0);
    check("lu_rt0", 32'(ctrl_a()), 32'(C_IDLE));
    drive(I_ADDI_R5, 1'b1, 5'd5, 1'b0, 1'b0);
    check("lu_addi_rt", 32'(ctrl_a()), 32'(C_IDLE));
    drive(I_SW_R5, 1'b1, 5'd5, 1'b0, 1'b0);
    check("lu_sw_rt", 32'(ctrl_a()), 32'(C_LU));
    step();
    drive(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("lu_sw_cnt", a_stall, 32'd2);

    // 3. Taken branch with two flush cycles
    drive(32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
    check("br_flush1", 32'(ctrl_a()), 32'(C_FLUSH));
    step();
    drive(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("br_flush2", 32'(ctrl_a()), 32'(C_FLUSH));
    step();
    settle();
    check("br_done", 32'(ctrl_a()), 32'(C_IDLE));
    check("br_flushcnt", a_flush, 32'd2);

    // 4. LU beats branch; then freeze with LU pending, then the LU stall
    drive(I_ADD_R2, 1'b1, 5'd2, 1'b1, 1'b0);
    check("lu_over_br", 32'(ctrl_a()), 32'(C_LU));
    step();
    for (int i = 0; i < 3; i++) begin
      drive(I_ADD_R2, 1'b1, 5'd2, 1'b0, 1'b1);
      check("frz_lu", 32'(ctrl_a()), 32'(C_FRZ));
      step();
    end
    drive(I_ADD_R2, 1'b1, 5'd2, 1'b0, 1'b0);
    check("frz_release_lu", 32'(ctrl_a()), 32'(C_LU));
    step();
    drive(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("t4_idle", 32'(ctrl_a()), 32'(C_IDLE));
    check("t4_stallcnt", a_stall, 32'd7);
    check("t4_flushcnt", a_flush, 32'd2);
    check("t4_no_timeout", 32'(a_to), 32'd0);

    // 5. Six busy cycles with timeout at 4
    for (int i = 1; i <= 6; i++) begin
      drive(32'h0, 1'b0, 5'd0, 1'b0, 1'b1);
      check("wait_ctrl", 32'(ctrl_a()), 32'(C_FRZ));
      step();
      check("wait_timeout", 32'(a_to), (i >= 4) ? 32'd1 : 32'd0);
    end
    drive(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("wait_release", 32'(ctrl_a()), 32'(C_IDLE));
    check("wait_stallcnt", a_stall, 32'd13);
    step();
    check("timeout_sticky", 32'(a_to), 32'd1);

    // 6. Three-cycle LU stall, then reset aborts a second one
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(I_ADD_R2, 1'b1, 5'd2, 1'b0, 1'b0);
    check("b_lu1", 32'(ctrl_b()), 32'(C_LU));
    step();
    drive(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("b_lu2", 32'(ctrl_b()), 32'(C_LU));
    step();
    check("b_lu3", 32'(ctrl_b()), 32'(C_LU));
    step();
    check("b_lu_done", 32'(ctrl_b()), 32'(C_IDLE));
    check("b_lu_cnt", 32'(b_stall), 32'd3);

    drive(I_ADD_R2, 1'b1, 5'd2, 1'b0, 1'b0);
    step();
    drive(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("b_mid_stall", 32'(ctrl_b()), 32'(C_LU));
    rst = 1'b1;
    settle();
    check("b_rst_force", 32'(ctrl_b()), 32'(C_RST));
    step();
    check("b_rst_stall0", 32'(b_stall), 32'd0);
    check("b_rst_flush0", 32'(b_flush), 32'd0);
    check("a_rst_timeout0", 32'(a_to), 32'd0);
    rst = 1'b0;
    settle();
    check("b_after_rst", 32'(ctrl_b()), 32'(C_IDLE));
    step();
    check("b_after_rst2", 32'(ctrl_b()), 32'(C_IDLE));
    check("b_after_rst_cnt", 32'(b_stall), 32'd0);

    // 4-bit stall counter saturates during a long wait
    drive(32'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step();
    check("b_sat", 32'(b_stall), 32'd15);
    check("b_no_timeout", 32'(b_to), 32'd0);
    check("a_timeout_long", 32'(a_to), 32'd1);
    drive(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    check("b_sat_hold", 32'(b_stall), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
